fp_mult: RTL and testbench
==========================

Name: fp_mult

Overview:
- Parameterised IEEE-754 floating-point multiplier; default is binary16 (1 sign, 5 exponent, 10 fraction bits).
- Used as the scalar multiply primitive in the datapath.
- The arithmetic path z = a*b is combinational: result valid in the same cycle the operands change.
- A clocked sticky-exception register accumulates status flags for software or debug.

Parameters:
- SIG_WIDTH, 10, stored fraction bits.
- EXP_WIDTH, 5, exponent bits; bias = 2^(EXP_WIDTH-1)-1.
- IEEE_COMPLIANCE, 1, 1 = full subnormal/NaN handling; 0 = subnormals flushed to zero, NaN treated as infinity.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- a  in  SIG_WIDTH+EXP_WIDTH+1  operand A.
- b  in  SIG_WIDTH+EXP_WIDTH+1  operand B.
- rnd  in  3  rounding mode.
- z  out  SIG_WIDTH+EXP_WIDTH+1  product.
- status  out  8  exception flags for the current z (combinational).
- flags_clr  in  1  synchronous clear of sticky flags.
- flags_sticky  out  8  OR-accumulated status since reset or clear.

Behaviour:
- Rounding modes (rnd): 0 RNE, 1 toward zero, 2 toward +inf, 3 toward -inf, 4 nearest ties-away, 5 away from zero. Values 6–7 behave as 0.
- status bits: [0] zero, [1] infinity, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] always 0.
- Sign: z sign = a sign XOR b sign, for all results including zero and infinity. Exception: NaN output has sign 0.
- Datapath:
  - Unpack each operand; subnormals get hidden bit 0 and exponent 1.
  - Form the (SIG_WIDTH+1)^2 product, 22 bits for the default.
  - Normalise with a leading-zero count, so subnormal inputs work.
  - Exponent = ea+eb-bias, with a signed internal width of EXP_WIDTH+2.
  - If the exponent is below 1, right-shift into the subnormal range and collect sticky bits.
  - Round using guard/round/sticky bits. A mantissa carry-out increments the exponent.
- Special cases, priority order:
  - Any NaN, or inf*0: canonical qNaN (sign 0, exponent all ones, fraction MSB 1; 16'h7E00 for default). Invalid=1 for inf*0 and for signalling NaNs.
  - inf*finite-nonzero: signed infinity; infinity=1.
  - Zero times finite: signed zero; zero=1.
- Overflow:
  - Huge=1 and inexact=1.
  - Result is infinity for RNE, ties-away, and away-from-zero modes, and for directed modes rounding away from zero.
  - Otherwise the result is max finite (16'h7BFF / 16'hFBFF).
- Underflow: tiny=1 when the pre-rounding result is below the minimum normal and inexact. If it rounds to zero, zero=1.
- Inexact = any discarded nonzero bit.
- Sticky register:
  - reset_n low → flags_sticky = 0, asynchronously.
  - Each posedge: flags_sticky <= flags_clr ? 0 : flags_sticky | status.
  - If clear and a new status occur in the same cycle, clear wins.
- No handshake. z and status are pure functions of a, b, rnd; they are independent of clk and reset_n.

Optional Feature:
- Macro FP_MULT_OUT_REG_EN.
- Defined:
  - z and status are registered on posedge clk; latency 1 cycle.
  - reset_n low forces z=0 and status=0.
  - Sticky flags accumulate from the registered status.
- Undefined: combinational z/status, latency 0, as described above.

Decomposition:
- Package fp_pkg holds:
  - Rounding-mode localparams: RND_NE, RND_ZERO, RND_PINF, RND_NINF, RND_UP, RND_AWAY.
  - Status bit index constants.
  - Default FP16 widths.
  - Canonical-NaN helper function.
- One sub-module, fp_round: takes the normalised mantissa, guard/round/sticky bits, sign and rnd; outputs the rounded mantissa, carry and inexact.

Test Plan:
- a=3C00, b=3C00, rnd=0 -> z=3C00, status=00. a=4000, b=4200 -> z=4600.
- a=3E00, b=C000 -> z=C200. a=8000, b=3C00 -> z=8000, status zero bit set.
- a=7BFF, b=7BFF, rnd=0 -> z=7C00, huge+inexact set; same operands with rnd=1 -> z=7BFF.
- a=7C00, b=0000 -> z=7E00, invalid set. a=7C00, b=C000 -> z=FC00, infinity set.
- a=0001, b=3800, rnd=0 -> z=0000, tiny+inexact+zero set. a=0001, b=4000 -> z=0002, exact.
- Sticky register:
  - Assert reset_n=0 mid-run -> flags_sticky=0 immediately.
  - Apply the overflow vector for one cycle, then 3C00*3C00 -> flags_sticky keeps huge+inexact.
  - Pulse flags_clr -> flags_sticky=00.
- Plus a 10000-vector random regression against a golden model, comparing bit-exact with RNE.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants for the floating-point multiplier: rounding modes,
// status bit positions, default binary16 widths and the canonical qNaN.
package fp_pkg;

  localparam int FP16_SIG = 10;
  localparam int FP16_EXP = 5;

  localparam logic [2:0] RND_NE   = 3'd0;  // nearest, ties to even
  localparam logic [2:0] RND_ZERO = 3'd1;  // toward zero
  localparam logic [2:0] RND_PINF = 3'd2;  // toward +inf
  localparam logic [2:0] RND_NINF = 3'd3;  // toward -inf
  localparam logic [2:0] RND_UP   = 3'd4;  // nearest, ties away from zero
  localparam logic [2:0] RND_AWAY = 3'd5;  // away from zero

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] canon_nan(input int ew, input int sw);
    return (((64'd1 << ew) - 64'd1) << sw) | (64'd1 << (sw - 1));
  endfunction

endpackage

// File: rtl/fp_round.sv
// Mantissa rounder: applies the selected rounding mode to a normalised
// (or denormalised) mantissa using guard/round/sticky bits.
module fp_round
  import fp_pkg::*;
#(
  parameter int MW = FP16_SIG + 1
) (
  input  logic [MW-1:0] mant,
  input  logic          guard,
  input  logic          round_bit,
  input  logic          sticky,
  input  logic          sign,
  input  logic [2:0]    rnd,
  output logic [MW-1:0] mant_r,
  output logic          carry,
  output logic          inexact
);

  logic inc;
  logic ne_up;

  assign inexact = guard | round_bit | sticky;
  assign ne_up   = guard & (round_bit | sticky | mant[0]);

  // Increment decision; unused encodings fall back to ties-to-even
  always_comb begin
    inc = 1'b0;
    case (rnd)
      RND_NE:   inc = ne_up;
      RND_ZERO: inc = 1'b0;
      RND_PINF: inc = ~sign & inexact;
      RND_NINF: inc = sign & inexact;
      RND_UP:   inc = guard;
      RND_AWAY: inc = inexact;
      default:  inc = ne_up;
    endcase
  end

  assign {carry, mant_r} = {1'b0, mant} + {{MW{1'b0}}, inc};

endmodule

// File: rtl/fp_mult.sv
// IEEE-754 multiplier (default binary16) with combinational product and
// status, plus a sticky exception register.
// Define FP_MULT_OUT_REG_EN to register z/status (1-cycle latency).
module fp_mult
  import fp_pkg::*;
#(
  parameter int SIG_WIDTH       = FP16_SIG,
  parameter int EXP_WIDTH       = FP16_EXP,
  parameter int IEEE_COMPLIANCE = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   b,
  input  logic [2:0]                     rnd,
  output logic [SIG_WIDTH+EXP_WIDTH:0]   z,
  output logic [7:0]                     status,
  input  logic                           flags_clr,
  output logic [7:0]                     flags_sticky
);

  localparam int W    = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int M    = SIG_WIDTH + 1;         // mantissa incl. hidden bit
  localparam int PW   = 2 * M;                 // raw product width
  localparam int EW   = EXP_WIDTH + 2;         // signed internal exponent
  localparam int LZW  = $clog2(PW + 1);
  localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;
  localparam int EMAX = 2 ** EXP_WIDTH - 1;
  localparam bit FLUSH = (IEEE_COMPLIANCE == 0);

  localparam logic [W-1:0]  QNAN     = W'(canon_nan(EXP_WIDTH, SIG_WIDTH));
  localparam logic [W-2:0]  INF_MAG  = {{EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
  localparam logic [W-2:0]  MAXF_MAG = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};
  localparam logic [EW-1:0] PW_E     = EW'(PW);
  localparam logic [EW-1:0] EMAX_E   = EW'(EMAX);

  // ---- unpack ----
  logic [EXP_WIDTH-1:0] ea_f, eb_f, ea_u, eb_u;
  logic [SIG_WIDTH-1:0] fa, fb;
  logic                 ea_one, eb_one, ea_nul, eb_nul;
  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                 sign, inf_x_zero;
  logic [M-1:0]         ma, mb;

  assign ea_f   = a[W-2:SIG_WIDTH];
  assign eb_f   = b[W-2:SIG_WIDTH];
  assign fa     = a[SIG_WIDTH-1:0];
  assign fb     = b[SIG_WIDTH-1:0];
  assign ea_one = &ea_f;
  assign eb_one = &eb_f;
  assign ea_nul = ~|ea_f;
  assign eb_nul = ~|eb_f;

  // Without full compliance NaNs read as infinity and subnormals as zero
  assign a_nan  = FLUSH ? 1'b0 : (ea_one & |fa);
  assign b_nan  = FLUSH ? 1'b0 : (eb_one & |fb);
  assign a_snan = a_nan & ~fa[SIG_WIDTH-1];
  assign b_snan = b_nan & ~fb[SIG_WIDTH-1];
  assign a_inf  = ea_one & (FLUSH | ~|fa);
  assign b_inf  = eb_one & (FLUSH | ~|fb);
  assign a_zero = ea_nul & (FLUSH | ~|fa);
  assign b_zero = eb_nul & (FLUSH | ~|fb);

  assign sign       = a[W-1] ^ b[W-1];
  assign inf_x_zero = (a_inf & b_zero) | (a_zero & b_inf);

  // Subnormals carry hidden bit 0 and an effective exponent of 1
  assign ma   = {~ea_nul, fa};
  assign mb   = {~eb_nul, fb};
  assign ea_u = ea_nul ? EXP_WIDTH'(1) : ea_f;
  assign eb_u = eb_nul ? EXP_WIDTH'(1) : eb_f;

  // ---- multiply and normalise ----
  logic [PW-1:0]  prod, pn;
  logic [LZW-1:0] lz;

  assign prod = PW'(ma) * PW'(mb);

  // Leading-zero count; the highest set bit wins
  always_comb begin
    lz = LZW'(PW);
    for (int i = 0; i < PW; i++)
      if (prod[i]) lz = LZW'(PW - 1 - i);
  end

  assign pn = prod << lz;

  // Biased exponent of the normalised product (two's complement in EW bits)
  logic [EW-1:0] e_sum, sh_amt, e_adj, e_fin;
  logic          is_sub;

  assign e_sum  = {2'b00, ea_u} + {2'b00, eb_u} - EW'(BIAS - 1) - EW'(lz);
  assign is_sub = e_sum[EW-1] | (e_sum == '0);
  assign sh_amt = EW'(1) - e_sum;
  assign e_adj  = is_sub ? '0 : e_sum;

  // ---- denormalise into the subnormal range ----
  logic [PW-1:0] xs, sh_mask;
  logic          sh_st;

  // Right shift below the minimum exponent, folding lost bits into sticky
  always_comb begin
    xs      = pn;
    sh_st   = 1'b0;
    sh_mask = (PW'(1) << sh_amt) - PW'(1);
    if (is_sub) begin
      if (sh_amt >= PW_E) begin
        xs    = '0;
        sh_st = |pn;
      end else begin
        xs    = pn >> sh_amt;
        sh_st = |(pn & sh_mask);
      end
    end
  end

  // ---- round ----
  logic [M-1:0] mant_r;
  logic         carry, inexact;

  fp_round #(.MW(M)) u_round (
    .mant      (xs[PW-1:M]),
    .guard     (xs[M-1]),
    .round_bit (xs[M-2]),
    .sticky    (|xs[M-3:0] | sh_st),
    .sign      (sign),
    .rnd       (rnd),
    .mant_r    (mant_r),
    .carry     (carry),
    .inexact   (inexact)
  );

  // Carry bumps the exponent; a subnormal rounding into the hidden bit
  // becomes the minimum normal
  assign e_fin = e_adj + EW'(carry) + EW'(is_sub & mant_r[M-1]);

  logic ovf, ovf_to_inf;
  assign ovf = ~is_sub & (e_fin >= EMAX_E);

  // Overflow saturates to max finite only when rounding toward zero
  always_comb begin
    ovf_to_inf = 1'b1;
    case (rnd)
      RND_ZERO: ovf_to_inf = 1'b0;
      RND_PINF: ovf_to_inf = ~sign;
      RND_NINF: ovf_to_inf = sign;
      default:  ovf_to_inf = 1'b1;
    endcase
  end

  // ---- result select with special-case priority ----
  logic [W-1:0] z_c;
  logic [7:0]   st_c;

  // Special cases first, then overflow, then the rounded finite result
  always_comb begin
    z_c  = '0;
    st_c = '0;
    if (a_nan | b_nan | inf_x_zero) begin
      z_c                = QNAN;
      st_c[ST_INVALID]   = a_snan | b_snan | inf_x_zero;
    end else if (a_inf | b_inf) begin
      z_c                = {sign, INF_MAG};
      st_c[ST_INF]       = 1'b1;
    end else if (a_zero | b_zero) begin
      z_c                = {sign, {(W-1){1'b0}}};
      st_c[ST_ZERO]      = 1'b1;
    end else if (FLUSH && is_sub) begin
      z_c                = {sign, {(W-1){1'b0}}};
      st_c[ST_ZERO]      = 1'b1;
      st_c[ST_TINY]      = 1'b1;
      st_c[ST_INEXACT]   = 1'b1;
    end else if (ovf) begin
      st_c[ST_HUGE]      = 1'b1;
      st_c[ST_INEXACT]   = 1'b1;
      if (ovf_to_inf) begin
        z_c              = {sign, INF_MAG};
        st_c[ST_INF]     = 1'b1;
      end else begin
        z_c              = {sign, MAXF_MAG};
      end
    end else begin
      z_c                = {sign, e_fin[EXP_WIDTH-1:0], mant_r[SIG_WIDTH-1:0]};
      st_c[ST_INEXACT]   = inexact;
      st_c[ST_TINY]      = is_sub & inexact;
      st_c[ST_ZERO]      = ~|{e_fin, mant_r};
    end
  end

`ifdef FP_MULT_OUT_REG_EN
  logic [W-1:0] z_q;
  logic [7:0]   st_q;

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_q  <= '0;
      st_q <= '0;
    end else begin
      z_q  <= z_c;
      st_q <= st_c;
    end
  end

  assign z      = z_q;
  assign status = st_q;
`else
  assign z      = z_c;
  assign status = st_c;
`endif

  // Sticky flags: clear takes precedence over new status in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       flags_sticky <= '0;
    else if (flags_clr) flags_sticky <= '0;
    else                flags_sticky <= flags_sticky | status;
  end

endmodule

// File: tb/tb_fp_mult.sv
// Self-checking bench for fp_mult (binary16 defaults): directed vectors,
// sticky-register behaviour and a randomized regression against a
// value-level reference model (exact integer product, quantum rounding).
module tb_fp_mult;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] a, b, z;
  logic [2:0]  rnd;
  logic [7:0]  status, flags_sticky;
  logic        flags_clr;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_z;
  logic [7:0]  exp_st;
  logic [7:0]  exp_sticky;

  fp_mult dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .a            (a),
    .b            (b),
    .rnd          (rnd),
    .z            (z),
    .status       (status),
    .flags_clr    (flags_clr),
    .flags_sticky (flags_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, expv);
    end
  endtask

  // Reference: value = ma*2^(ea-25); choose quantum 2^k of the result,
  // divide, and round the remainder against half a quantum.
  function automatic void model(input logic [15:0] ia, input logic [15:0] ib,
                                input logic [2:0] rm,
                                output logic [15:0] oz, output logic [7:0] ost);
    int     ea, eb, fa, fb, x, t, k, sh, ef;
    longint p, q, rem, half;
    bit     s, na, nb, sna, snb, ia_inf, ib_inf, za, zb, inx, up, tiny, to_inf;
    ea = int'(ia[14:10]); eb = int'(ib[14:10]);
    fa = int'(ia[9:0]);   fb = int'(ib[9:0]);
    s  = ia[15] ^ ib[15];
    na = (ea == 31) && (fa != 0);  nb = (eb == 31) && (fb != 0);
    sna = na && !ia[9];            snb = nb && !ib[9];
    ia_inf = (ea == 31) && (fa == 0); ib_inf = (eb == 31) && (fb == 0);
    za = (ea == 0) && (fa == 0);   zb = (eb == 0) && (fb == 0);
    oz = 16'h0; ost = 8'h0;
    if (na || nb || (ia_inf && zb) || (za && ib_inf)) begin
      oz = 16'h7E00;
      ost[2] = sna || snb || (ia_inf && zb) || (za && ib_inf);
    end else if (ia_inf || ib_inf) begin
      oz = {s, 15'h7C00}; ost[1] = 1'b1;
    end else if (za || zb) begin
      oz = {s, 15'h0}; ost[0] = 1'b1;
    end else begin
      p = longint'((ea == 0) ? fa : fa + 1024) * longint'((eb == 0) ? fb : fb + 1024);
      x = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 50;
      t = 0;
      for (int i = 0; i < 24; i++) if (p[i]) t = i;
      k = t + x - 10;
      if (k < -24) k = -24;
      if (k >= x) begin
        sh   = k - x;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
      end else begin
        q = p << (x - k); rem = 0; half = 0;
      end
      inx  = (rem != 0);
      tiny = ((t + x) < -14) && inx;
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = !s && inx;
        3'd3:    up = s && inx;
        3'd4:    up = inx && (rem >= half);
        3'd5:    up = inx;
        default: up = inx && ((rem > half) || ((rem == half) && q[0]));
      endcase
      if (up) q = q + 1;
      if (q == 2048) begin q = 1024; k = k + 1; end
      ef = (q >= 1024) ? k + 25 : 0;
      if (ef >= 31) begin
        case (rm)
          3'd1:    to_inf = 1'b0;
          3'd2:    to_inf = !s;
          3'd3:    to_inf = s;
          default: to_inf = 1'b1;
        endcase
        ost[4] = 1'b1; ost[5] = 1'b1;
        if (to_inf) begin oz = {s, 15'h7C00}; ost[1] = 1'b1; end
        else        oz = {s, 15'h7BFF};
      end else begin
        oz = {s, 5'(ef), 10'(q)};
        ost[5] = inx; ost[3] = tiny; ost[0] = (q == 0);
      end
    end
  endfunction

  // Drive at negedge, let one posedge pass, sample just after it
  task automatic apply(input logic [15:0] ta, input logic [15:0] tb2,
                       input logic [2:0] tr, input logic clr);
    @(negedge clk);
    a = ta; b = tb2; rnd = tr; flags_clr = clr;
    model(ta, tb2, tr, exp_z, exp_st);
    @(posedge clk);
    #1;
    exp_sticky = clr ? 8'h00 : (exp_sticky | exp_st);
  endtask

  task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                          input logic [2:0] tr, input logic [15:0] ez, input logic [7:0] est);
    apply(ta, tb2, tr, 1'b0);
    chk({tag, "_z"}, 32'(z), 32'(ez));
    chk({tag, "_st"}, 32'(status), 32'(est));
  endtask

  function automatic logic [15:0] rand_op();
    int          c;
    logic [15:0] v;
    c = $urandom_range(0, 11);
    v = 16'($urandom);
    case (c)
      0: v[14:0] = 15'h0;
      1: v[14:0] = 15'h7C00;
      2: begin v[14:10] = 5'h1F; if (v[9:0] == 10'h0) v[0] = 1'b1; end
      3: v[14:10] = 5'h0;
      4: v[14:10] = 5'($urandom_range(27, 30));
      5: v[14:10] = 5'($urandom_range(1, 4));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [15:0] ra, rb;
    logic [2:0]  rr;
    reset_n = 1'b0; flags_clr = 1'b0;
    a = 16'h3C00; b = 16'h3C00; rnd = 3'd0;   // status 0 while idle
    exp_sticky = 8'h00;
    #12;
    chk("rst_sticky", 32'(flags_sticky), 32'h0);
    @(negedge clk); reset_n = 1'b1;

    directed("one_one",  16'h3C00, 16'h3C00, 3'd0, 16'h3C00, 8'h00);
    directed("two_three",16'h4000, 16'h4200, 3'd0, 16'h4600, 8'h00);
    directed("neg",      16'h3E00, 16'hC000, 3'd0, 16'hC200, 8'h00);
    directed("negzero",  16'h8000, 16'h3C00, 3'd0, 16'h8000, 8'h01);
    directed("ovf_rne",  16'h7BFF, 16'h7BFF, 3'd0, 16'h7C00, 8'h32);
    directed("ovf_rz",   16'h7BFF, 16'h7BFF, 3'd1, 16'h7BFF, 8'h30);
    directed("inf_zero", 16'h7C00, 16'h0000, 3'd0, 16'h7E00, 8'h04);
    directed("inf_neg",  16'h7C00, 16'hC000, 3'd0, 16'hFC00, 8'h02);
    directed("unf_zero", 16'h0001, 16'h3800, 3'd0, 16'h0000, 8'h29);
    directed("sub_exact",16'h0001, 16'h4000, 3'd0, 16'h0002, 8'h00);
    directed("ovf_ninf", 16'h7BFF, 16'h7BFF, 3'd3, 16'h7BFF, 8'h30);
    directed("ovf_ninfn",16'hFBFF, 16'h7BFF, 3'd3, 16'hFC00, 8'h32);
    chk("sticky_acc", 32'(flags_sticky), 32'h3F);

    // clear wins over a simultaneous new status
    apply(16'h7BFF, 16'h7BFF, 3'd0, 1'b1);
    chk("clr_wins", 32'(flags_sticky), 32'h00);
    apply(16'h7BFF, 16'h7BFF, 3'd0, 1'b0);
    apply(16'h3C00, 16'h3C00, 3'd0, 1'b0);
    chk("sticky_hold", 32'(flags_sticky), 32'h32);
    apply(16'h3C00, 16'h3C00, 3'd0, 1'b1);
    chk("sticky_clr", 32'(flags_sticky), 32'h00);

    // asynchronous reset mid-run
    apply(16'h7BFF, 16'h7BFF, 3'd0, 1'b0);
    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; rnd = 3'd0;
    reset_n = 1'b0;
    #1;
    chk("async_rst", 32'(flags_sticky), 32'h00);
    exp_sticky = 8'h00;
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      ra = rand_op(); rb = rand_op();
      apply(ra, rb, 3'd0, 1'b0);
      chk($sformatf("rne_z a=%h b=%h", ra, rb), 32'(z), 32'(exp_z));
      chk($sformatf("rne_st a=%h b=%h", ra, rb), 32'(status), 32'(exp_st));
    end
    for (int i = 0; i < 2000; i++) begin
      ra = rand_op(); rb = rand_op(); rr = 3'($urandom_range(0, 7));
      apply(ra, rb, rr, 1'b0);
      chk($sformatf("rm_z a=%h b=%h r=%0d", ra, rb, rr), 32'(z), 32'(exp_z));
      chk($sformatf("rm_st a=%h b=%h r=%0d", ra, rb, rr), 32'(status), 32'(exp_st));
    end
    chk("sticky_rand", 32'(flags_sticky), 32'(exp_sticky));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
